snn_wmem_arbiter: RTL
=====================

# snn_wmem_arbiter

Arbiter and sequencer for the SNN's single-port weight memory (16 x 8-bit by default, registered 1-cycle read). It shares the memory between three requesters:

- the host weight loader (writes),
- the multilayer inference engine (reads),
- the reward-learning unit (atomic read-modify-write: add a signed delta to a stored weight).

It sits between those requesters and the memory instance in the top level.

## Interface
Parameters:
- ADDR_W, 4, weight address width
- DW, 8, weight width; weights and deltas are two's-complement

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- host_we  in  1  host write request
- host_addr  in  ADDR_W  host write address
- host_wdata  in  DW  host write data
- host_gnt  out  1  host write accepted this cycle
- rd_req  in  1  inference read request
- rd_addr  in  ADDR_W  inference read address
- rd_gnt  out  1  inference read accepted this cycle
- rd_valid  out  1  read data valid; one-cycle pulse
- rd_data  out  DW  read data
- upd_req  in  1  reward-update request
- upd_addr  in  ADDR_W  update address
- upd_delta  in  DW  signed delta
- upd_gnt  out  1  update accepted this cycle
- upd_done  out  1  update written; one-cycle pulse
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid the cycle after the address is presented

## Operation
- State machine: IDLE and UPD_WR.
- Memory outputs, gnt signals and rd_valid/rd_data are combinational from state and inputs. Registered state: FSM, rd_pend, the update address/delta latch, the round-robin pointer rr, and upd_done.
- In IDLE, at most one grant per cycle:
  - host_we has absolute priority.
  - Otherwise rd_req vs upd_req are arbitrated round-robin. rr=0 favours rd; rr=1 favours upd.
  - rr toggles only when both rd_req and upd_req were pending and one of them was granted.
- Host grant: mem_we=1, mem_addr=host_addr, mem_wdata=host_wdata. The write completes at that edge.
- Read grant: mem_addr=rd_addr and rd_pend is set. Next cycle: rd_valid=1, rd_data=mem_rdata.
  - Back-to-back reads are allowed, one per cycle.
- Update grant: mem_addr=upd_addr; addr and delta are latched; next state is UPD_WR.
- UPD_WR: mem_we=1, mem_addr=latched address, mem_wdata=f(mem_rdata, delta). No grant of any kind is issued. Next state IDLE, with upd_done=1 in the following cycle.
  - The RMW is atomic and is never pre-empted, including by host_we.
- Arithmetic: the sum is formed at DW+1 bits, signed.
- Requesters hold req and payload stable until gnt. Payload is sampled only in the grant cycle.
- Reset mid-RMW: the write is dropped. mem_we and all gnt outputs are forced to 0 while rst=1.
- Reset values: state IDLE, rr=0, rd_pend=0, upd_done=0. Consequently rd_valid=0, all gnt=0, mem_we=0, mem_addr=0, mem_wdata=0.

## Timing
- Host write: accepted in cycle N; the memory is updated at the end of cycle N.
- Read: granted in cycle N; rd_valid in N+1. Throughput is 1 read per cycle.
- Update: granted in cycle N; write in N+1; upd_done in N+2. The earliest next grant of any kind is N+2.
- A read granted in N followed by a host write in N+1 is legal. rd_data in N+1 is the pre-write value.
- Worst-case read wait with upd_req continuously asserted and no host traffic is 2 cycles, from round-robin plus UPD_WR. Host traffic can starve both rd and upd by design.

## Configuration
- SNN_WMEM_SAT_EN defined: the update result is clamped to [-2^(DW-1), 2^(DW-1)-1]. For DW=8 that is [-128, 127].
- SNN_WMEM_SAT_EN undefined: the update result wraps modulo 2^DW.

## Structure
- Shared package snn_pkg holds:
  - ADDR_W and DW default constants;
  - the state enum wmem_state_t (IDLE, UPD_WR).
- One sub-module: snn_sat_add. It is combinational, DW-bit signed a+b, and contains the SNN_WMEM_SAT_EN saturate/wrap selection.

## Test plan
- Reset: assert rst for 2 cycles with all requests high → all gnt=0, mem_we=0, rd_valid=0, upd_done=0 throughout.
- Host then read: write 0x5A to addr 3, then rd_req addr 3 in the next cycle → rd_gnt that cycle; rd_valid one cycle later with rd_data=0x5A.
- Update saturation: addr 7=0x7E, delta=+5 → upd_done at N+2; a following read of addr 7 returns 0x7F with SAT_EN defined, 0x83 without.
- Contention: rd_req and upd_req both held for 6 cycles from reset, no host traffic → grant order rd, upd, (UPD_WR, no grant), rd, upd, … ; no grant is ever issued in UPD_WR.
- Host priority and atomicity: host_we raised during UPD_WR → host_gnt=0 in UPD_WR and 1 the next cycle; the update result is written intact.
- Reset mid-RMW: assert rst during UPD_WR → mem_we=0 and the weight is unchanged on a later read; upd_done never pulses.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared constants and types for the SNN weight-memory datapath.
package snn_pkg;

    localparam int SNN_ADDR_W = 4;
    localparam int SNN_DW     = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        UPD_WR = 1'b1
    } wmem_state_t;

endpackage

// File: rtl/snn_sat_add.sv
// Combinational DW-bit signed adder; clamps on overflow when SNN_WMEM_SAT_EN
// is defined, otherwise wraps modulo 2^DW.
module snn_sat_add #(
    parameter int DW = 8
) (
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    output logic [DW-1:0] y_o
);

    logic [DW:0] sum_full;

    assign sum_full = {a_i[DW-1], a_i} + {b_i[DW-1], b_i};

`ifdef SNN_WMEM_SAT_EN
    logic overflow;

    // Sign bit and the bit below it disagree only when the DW-bit result overflowed.
    assign overflow = sum_full[DW] ^ sum_full[DW-1];
    assign y_o = !overflow   ? sum_full[DW-1:0] :
                 sum_full[DW] ? {1'b1, {(DW-1){1'b0}}} :
                                {1'b0, {(DW-1){1'b1}}};
`else
    logic unused_msb;

    assign unused_msb = sum_full[DW];
    assign y_o        = sum_full[DW-1:0];
`endif

endmodule

// File: rtl/snn_wmem_arbiter.sv
// Arbitrates the single-port weight memory between host writes, inference
// reads and atomic reward updates. Saturating updates: define SNN_WMEM_SAT_EN.
module snn_wmem_arbiter
    import snn_pkg::*;
#(
    parameter int ADDR_W = SNN_ADDR_W,
    parameter int DW     = SNN_DW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DW-1:0]     host_wdata,
    output logic              host_gnt,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic [DW-1:0]     rd_data,
    input  logic              upd_req,
    input  logic [ADDR_W-1:0] upd_addr,
    input  logic [DW-1:0]     upd_delta,
    output logic              upd_gnt,
    output logic              upd_done,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic [DW-1:0]     mem_rdata
);

    wmem_state_t       state_q, state_d;
    logic              rr_q, rr_d;
    logic              rd_pend_q;
    logic              upd_done_q;
    logic [ADDR_W-1:0] upd_addr_q, upd_addr_d;
    logic [DW-1:0]     upd_delta_q, upd_delta_d;
    logic [DW-1:0]     upd_result;

    snn_sat_add #(.DW(DW)) u_sat_add (
        .a_i (mem_rdata),
        .b_i (upd_delta_q),
        .y_o (upd_result)
    );

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        upd_addr_d  = upd_addr_q;
        upd_delta_d = upd_delta_q;
        host_gnt    = 1'b0;
        rd_gnt      = 1'b0;
        upd_gnt     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;

        // Reset squashes everything, including an in-flight RMW write.
        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    if (host_we) begin
                        host_gnt  = 1'b1;
                        mem_we    = 1'b1;
                        mem_addr  = host_addr;
                        mem_wdata = host_wdata;
                    end else if (rd_req && (!upd_req || !rr_q)) begin
                        rd_gnt   = 1'b1;
                        mem_addr = rd_addr;
                    end else if (upd_req) begin
                        upd_gnt     = 1'b1;
                        mem_addr    = upd_addr;
                        upd_addr_d  = upd_addr;
                        upd_delta_d = upd_delta;
                        state_d     = UPD_WR;
                    end
                    if (rd_req && upd_req && !host_we) begin
                        rr_d = ~rr_q;
                    end
                end
                UPD_WR: begin
                    mem_we    = 1'b1;
                    mem_addr  = upd_addr_q;
                    mem_wdata = upd_result;
                    state_d   = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_q        <= 1'b0;
            rd_pend_q   <= 1'b0;
            upd_done_q  <= 1'b0;
            upd_addr_q  <= '0;
            upd_delta_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            rd_pend_q   <= rd_gnt;
            upd_done_q  <= (state_q == UPD_WR);
            upd_addr_q  <= upd_addr_d;
            upd_delta_q <= upd_delta_d;
        end
    end

    assign rd_valid = rd_pend_q;
    assign rd_data  = rd_pend_q ? mem_rdata : '0;
    assign upd_done = upd_done_q;

endmodule
